// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: lets two requesters take turns using one shared ALU.
//   Requesters are chosen round-robin. The winner's operands are registered
//   onto the ALU inputs, the ALU result is captured one cycle later, and it is
//   returned on a tagged valid/ready response channel. Only one operation is
//   in flight at a time.
// Ports:
//   clk, rst                        clock (rising edge), synchronous active-high reset
//   reqN_valid/ready/a/b/op         request channel N (N = 0, 1)
//   alu_a, alu_b, alu_op            registered operands/opcode to the shared ALU
//   alu_result/zero/overflow        ALU outputs (combinational from alu_*)
//   resp_valid/ready                response handshake
//   resp_id, resp_result, resp_zero, resp_overflow, resp_illegal  captured response
module alu_share_ctrl #(
   parameter int unsigned WIDTH     = 32,
   parameter bit          PRIO_INIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [3:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [3:0]       req1_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   input  logic             alu_overflow,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [WIDTH-1:0] resp_result,
   output logic             resp_zero,
   output logic             resp_overflow,
   output logic             resp_illegal
);

   typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_t;

   state_t           state_q, state_d;
   logic             prio_q;
   logic             grant0, grant1, accept, win_id;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic [3:0]       sel_op;
   logic             sel_legal;
   logic [WIDTH-1:0] alu_a_q, alu_b_q, res_q;
   logic [3:0]       alu_op_q;
   logic             id_q, illegal_q, rid_q, zero_q, ovf_q, rill_q;

   function automatic logic is_legal(input logic [3:0] op);
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: is_legal = 1'b1;
         default:                                              is_legal = 1'b0;
      endcase
   endfunction

   // Next state and grant
   always_comb begin
      state_d = state_q;
      grant0  = 1'b0;
      grant1  = 1'b0;
      case (state_q)
         StIdle: begin
            if (!rst) begin
               if (req0_valid && req1_valid) begin
                  grant0 = !prio_q;
                  grant1 = prio_q;
               end else begin
                  grant0 = req0_valid;
                  grant1 = req1_valid;
               end
            end
            if (grant0 || grant1) state_d = StIssue;
         end
         StIssue:   state_d = StCapture;
         StCapture: if (resp_ready) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   assign accept    = grant0 | grant1;
   assign win_id    = grant1;
   assign sel_a     = win_id ? req1_a  : req0_a;
   assign sel_b     = win_id ? req1_b  : req0_b;
   assign sel_op    = win_id ? req1_op : req0_op;
   assign sel_legal = is_legal(sel_op);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         prio_q    <= PRIO_INIT;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_op_q  <= '0;
         id_q      <= 1'b0;
         illegal_q <= 1'b0;
         res_q     <= '0;
         rid_q     <= 1'b0;
         zero_q    <= 1'b0;
         ovf_q     <= 1'b0;
         rill_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            // Pointer always moves away from the winner, even with a single requester.
            prio_q    <= ~win_id;
            alu_a_q   <= sel_legal ? sel_a  : '0;
            alu_b_q   <= sel_legal ? sel_b  : '0;
            alu_op_q  <= sel_legal ? sel_op : 4'b0000;
            id_q      <= win_id;
            illegal_q <= !sel_legal;
         end
         if (state_q == StIssue) begin
            res_q  <= illegal_q ? '0 : alu_result;
            zero_q <= !illegal_q && alu_zero;
            // Overflow is only meaningful for add and sub.
            ovf_q  <= !illegal_q && alu_overflow &&
                      ((alu_op_q == 4'b0010) || (alu_op_q == 4'b0110));
            rill_q <= illegal_q;
            rid_q  <= id_q;
         end
      end
   end

   assign req0_ready    = grant0;
   assign req1_ready    = grant1;
   assign alu_a         = alu_a_q;
   assign alu_b         = alu_b_q;
   assign alu_op        = alu_op_q;
   assign resp_valid    = (state_q == StCapture);
   assign resp_id       = rid_q;
   assign resp_result   = res_q;
   assign resp_zero     = zero_q;
   assign resp_overflow = ovf_q;
   assign resp_illegal  = rill_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: self-checking bench for alu_share_ctrl with a behavioural ALU.
module tb_alu_share_ctrl;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req1_valid, req0_ready, req1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]   req0_op, req1_op;
   logic [W-1:0] alu_a, alu_b, alu_result;
   logic [3:0]   alu_op;
   logic         alu_zero, alu_overflow;
   logic         resp_valid, resp_ready, resp_id, resp_zero, resp_overflow, resp_illegal;
   logic [W-1:0] resp_result;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   alu_share_ctrl #(.WIDTH(W), .PRIO_INIT(1'b0)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_result(resp_result), .resp_zero(resp_zero),
      .resp_overflow(resp_overflow), .resp_illegal(resp_illegal)
   );

   // Behavioural ALU; slt also reports the subtract overflow so qualification is exercised.
   logic [W-1:0] m_sum, m_diff;
   always_comb begin
      m_sum        = alu_a + alu_b;
      m_diff       = alu_a - alu_b;
      alu_result   = '0;
      alu_overflow = 1'b0;
      case (alu_op)
         4'b0000: alu_result = alu_a & alu_b;
         4'b0001: alu_result = alu_a | alu_b;
         4'b0010: begin
            alu_result   = m_sum;
            alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (m_sum[W-1] != alu_a[W-1]);
         end
         4'b0110: begin
            alu_result   = m_diff;
            alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (m_diff[W-1] != alu_a[W-1]);
         end
         4'b0111: begin
            alu_result   = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (m_diff[W-1] != alu_a[W-1]);
         end
         4'b1100: alu_result = ~(alu_a | alu_b);
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic set_req(input bit id, input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] op);
      if (id) begin
         req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
      end else begin
         req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Single operation on one requester; resp_ready assumed high.
   task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] op, input logic [W-1:0] er, input bit ez,
                        input bit eo, input bit ei);
      bit got = 1'b0;
      @(negedge clk);
      set_req(id, 1'b1, a, b, op);
      for (int i = 0; i < 10 && !got; i++) begin
         #1;
         if (id ? req1_ready : req0_ready) got = 1'b1;
         else @(negedge clk);
      end
      check("accept", {63'd0, got}, 64'd1);
      if (got) begin
         @(posedge clk);
         @(negedge clk);
         set_req(id, 1'b0, '0, '0, 4'b0000);
         check("issue_no_resp", {63'd0, resp_valid}, 64'd0);
         check("alu_op", {60'd0, alu_op}, {60'd0, (ei ? 4'b0000 : op)});
         @(negedge clk);
         check("resp_valid", {63'd0, resp_valid}, 64'd1);
         check("resp_id", {63'd0, resp_id}, {63'd0, id});
         check("resp_result", {32'd0, resp_result}, {32'd0, er});
         check("resp_flags", {61'd0, resp_zero, resp_overflow, resp_illegal},
               {61'd0, ez, eo, ei});
      end else begin
         set_req(id, 1'b0, '0, '0, 4'b0000);
      end
   endtask

   // Both requesters valid at once; checks order, results and accept spacing.
   task automatic run_pair(input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [3:0] op0,
                           input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [3:0] op1,
                           input logic [W-1:0] r0, input logic [W-1:0] r1, input bit first);
      int acc0 = -1, acc1 = -1, nresp = 0;
      bit drop0, drop1;
      logic ids [2];
      logic [W-1:0] res [2];
      @(negedge clk);
      resp_ready = 1'b1;
      set_req(1'b0, 1'b1, a0, b0, op0);
      set_req(1'b1, 1'b1, a1, b1, op1);
      for (int cyc = 0; cyc < 20 && nresp < 2; cyc++) begin
         #1;
         drop0 = req0_valid && req0_ready;
         drop1 = req1_valid && req1_ready;
         if (drop0) acc0 = cyc;
         if (drop1) acc1 = cyc;
         if (resp_valid && resp_ready) begin
            ids[nresp] = resp_id;
            res[nresp] = resp_result;
            nresp++;
         end
         @(negedge clk);
         if (drop0) set_req(1'b0, 1'b0, '0, '0, 4'b0000);
         if (drop1) set_req(1'b1, 1'b0, '0, '0, 4'b0000);
      end
      set_req(1'b0, 1'b0, '0, '0, 4'b0000);
      set_req(1'b1, 1'b0, '0, '0, 4'b0000);
      check("pair_responses", nresp, 2);
      if (nresp == 2) begin
         check("pair_first_id", {63'd0, ids[0]}, {63'd0, first});
         check("pair_second_id", {63'd0, ids[1]}, {63'd0, !first});
         check("pair_first_res", {32'd0, res[0]}, {32'd0, (first ? r1 : r0)});
         check("pair_second_res", {32'd0, res[1]}, {32'd0, (first ? r0 : r1)});
         check("pair_spacing", first ? (acc0 - acc1) : (acc1 - acc0), 3);
      end
   endtask

   typedef struct {
      bit           id;
      logic [W-1:0] a, b;
      logic [3:0]   op;
      logic [W-1:0] res;
      bit           z, o, ill;
   } vec_t;

   vec_t vecs [10];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{0, 32'd77,        32'd33, 4'b0000, 32'd1,         0, 0, 0};
      vecs[1] = '{1, 32'h7FFFFFFF,  32'd1,  4'b0010, 32'h80000000,  0, 1, 0};
      vecs[2] = '{1, 32'h80000000,  32'd1,  4'b0110, 32'h7FFFFFFF,  0, 1, 0};
      vecs[3] = '{1, 32'h80000000,  32'd1,  4'b0111, 32'd1,         0, 0, 0};
      vecs[4] = '{0, 32'hF0,        32'h0F, 4'b0001, 32'hFF,        0, 0, 0};
      vecs[5] = '{0, 32'd0,         32'd0,  4'b1100, 32'hFFFFFFFF,  0, 0, 0};
      vecs[6] = '{0, 32'hF0,        32'h0F, 4'b0000, 32'd0,         1, 0, 0};
      vecs[7] = '{1, 32'd5,         32'd5,  4'b0110, 32'd0,         1, 0, 0};
      vecs[8] = '{0, 32'd9,         32'd9,  4'b0011, 32'd0,         0, 0, 1};
      vecs[9] = '{1, 32'd1,         32'd2,  4'b1111, 32'd0,         0, 0, 1};

      rst = 1'b1;
      resp_ready = 1'b1;
      set_req(1'b0, 1'b1, 32'd1, 32'd2, 4'b0010);
      set_req(1'b1, 1'b1, 32'd3, 32'd4, 4'b0010);
      @(negedge clk);
      @(negedge clk);
      #1;
      check("ready_in_reset", {62'd0, req0_ready, req1_ready}, 64'd0);
      set_req(1'b0, 1'b0, '0, '0, 4'b0000);
      set_req(1'b1, 1'b0, '0, '0, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_outputs", {alu_a, alu_b}, 64'd0);
      check("reset_resp", {20'd0, alu_op, resp_valid, resp_id, resp_zero, resp_overflow,
                           resp_illegal, resp_result[W-1:0]}, 64'd0);

      // Arbitration straight out of reset: req0 holds priority.
      run_pair(32'd77, 32'd33, 4'b0110, 32'd33, 32'd77, 4'b0111, 32'd44, 32'd1, 1'b0);

      for (int i = 0; i < 10; i++)
         do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res,
               vecs[i].z, vecs[i].o, vecs[i].ill);

      // A lone req0 grant hands priority to req1.
      do_reset();
      do_op(1'b0, 32'd2, 32'd3, 4'b0010, 32'd5, 0, 0, 0);
      run_pair(32'd8, 32'd1, 4'b0110, 32'd6, 32'd6, 4'b0000, 32'd7, 32'd6, 1'b1);

      // Backpressure: response held for 5 cycles, handshake on the 6th.
      do_reset();
      @(negedge clk);
      resp_ready = 1'b0;
      set_req(1'b0, 1'b1, 32'd3, 32'd4, 4'b0010);
      set_req(1'b1, 1'b1, 32'd1, 32'd2, 4'b0001);
      #1;
      check("bp_req0_ready", {63'd0, req0_ready}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      set_req(1'b0, 1'b0, '0, '0, 4'b0000);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         #1;
         check("bp_hold", {29'd0, resp_valid, resp_id, resp_result, req0_ready, req1_ready},
               {29'd0, 1'b1, 1'b0, 32'd7, 2'b00});
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      #1;
      check("bp_next_accept", {62'd0, req0_ready, req1_ready}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      set_req(1'b1, 1'b0, '0, '0, 4'b0000);
      @(negedge clk);
      check("bp_second_resp", {31'd0, resp_valid, resp_result}, {31'd0, 1'b1, 32'd3});

      // Reset during ISSUE discards the operation and restores the pointer.
      do_reset();
      @(negedge clk);
      set_req(1'b0, 1'b1, 32'd5, 32'd3, 4'b0010);
      #1;
      check("rst_issue_accept", {63'd0, req0_ready}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      set_req(1'b0, 1'b0, '0, '0, 4'b0000);
      check("rst_issue_alu_a", {32'd0, alu_a}, 64'd5);
      rst = 1'b1;
      @(negedge clk);
      check("rst_issue_alu", {alu_a, alu_b}, 64'd0);
      check("rst_issue_resp", {20'd0, alu_op, resp_valid, resp_id, resp_zero, resp_overflow,
                               resp_illegal, resp_result[W-1:0]}, 64'd0);
      rst = 1'b0;
      begin
         bit seen = 1'b0;
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
         end
         check("rst_no_resp", {63'd0, seen}, 64'd0);
      end
      run_pair(32'd10, 32'd4, 4'b0110, 32'd4, 32'd10, 4'b0111, 32'd6, 32'd1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
